// File: rtl/sram_resp.sv
// Single-port 32-bit word SRAM with one-cycle registered reads, byte-lane writes,
// optional zero-fill after reset and out-of-range access tracking.
module sram_resp #(
   parameter int ADDR_W    = 10,
   parameter int INIT_ZERO = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        sram_en,
   input  logic [3:0]  sram_wen,
   input  logic [31:0] sram_addr,
   input  logic [31:0] sram_wdata,
   output logic [31:0] sram_rdata,
   output logic        init_done,
   output logic [15:0] oor_cnt,
   output logic [31:0] last_err_addr
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {INIT, READY} state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] init_cnt;
   logic [ADDR_W-1:0] word_idx;
   logic              out_of_range;
   logic [31:0]       mem [DEPTH];

   assign word_idx     = sram_addr[ADDR_W+1:2];
   assign out_of_range = (sram_addr >> (ADDR_W + 2)) != 32'd0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= (INIT_ZERO != 0) ? INIT : READY;
      end else begin
         state <= state_next;
      end
   end

   // Zero-fill finishes on the edge that clears the last word.
   always_comb begin
      state_next = state;
      case (state)
         INIT:    if (&init_cnt) state_next = READY;
         READY:   state_next = READY;
         default: state_next = state;
      endcase
   end

   always_comb begin
      init_done = (state == READY);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         init_cnt <= '0;
      end else if (state == INIT) begin
         init_cnt <= init_cnt + ADDR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sram_rdata    <= '0;
         oor_cnt       <= '0;
         last_err_addr <= '0;
      end else if (sram_en) begin
         if (state == INIT || out_of_range) begin
            sram_rdata <= '0;
         end else begin
            sram_rdata <= mem[word_idx];
         end
         if (state == READY && out_of_range) begin
            last_err_addr <= sram_addr;
            if (oor_cnt != 16'hFFFF) begin
               oor_cnt <= oor_cnt + 16'd1;
            end
         end
      end
   end

   // The array has no reset; writes are gated off while reset is held so
   // contents survive reset untouched when zero-fill is disabled.
   always_ff @(posedge clk) begin
      if (resetn) begin
         if (state == INIT) begin
            mem[init_cnt] <= '0;
         end else if (sram_en && !out_of_range) begin
            for (int i = 0; i < 4; i++) begin
               if (sram_wen[i]) begin
                  mem[word_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_resp.sv
// Randomized and directed bench for sram_resp (ADDR_W=4) against a
// word-array reference model.
module tb_sram_resp;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        sram_en = 1'b0;
   logic [3:0]  sram_wen = 4'h0;
   logic [31:0] sram_addr = 32'h0;
   logic [31:0] sram_wdata = 32'h0;
   logic [31:0] sram_rdata;
   logic        init_done;
   logic [15:0] oor_cnt;
   logic [31:0] last_err_addr;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [DEPTH];
   logic [31:0] rdata_m;
   logic [31:0] last_m;
   int          oor_m;
   int          init_edges_m;

   sram_resp #(.ADDR_W(ADDR_W), .INIT_ZERO(1)) dut (
      .clk(clk),
      .resetn(resetn),
      .sram_en(sram_en),
      .sram_wen(sram_wen),
      .sram_addr(sram_addr),
      .sram_wdata(sram_wdata),
      .sram_rdata(sram_rdata),
      .init_done(init_done),
      .oor_cnt(oor_cnt),
      .last_err_addr(last_err_addr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Zero-fill makes the whole array read as zero once the module is ready.
   task automatic modelReset();
      rdata_m      = 32'h0;
      last_m       = 32'h0;
      oor_m        = 0;
      init_edges_m = 0;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
   endtask

   task automatic modelEdge(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
      int idx;
      if (init_edges_m < DEPTH) begin
         init_edges_m++;
         if (en) rdata_m = 32'h0;
      end else if (en) begin
         if (addr >= 32'(DEPTH * 4)) begin
            rdata_m = 32'h0;
            last_m  = addr;
            if (oor_m < 65535) oor_m++;
         end else begin
            idx     = int'(addr) / 4;
            rdata_m = mem_m[idx];
            for (int b = 0; b < 4; b++) begin
               if (wen[b]) mem_m[idx][8*b +: 8] = wdata[8*b +: 8];
            end
         end
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "/rdata"}, sram_rdata, rdata_m);
      checkOutput({tag, "/init_done"}, {31'h0, init_done}, {31'h0, init_edges_m >= DEPTH});
      checkOutput({tag, "/oor_cnt"}, {16'h0, oor_cnt}, 32'(oor_m));
      checkOutput({tag, "/last_err"}, last_err_addr, last_m);
   endtask

   task automatic applyStimulus(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit do_check, input string tag);
      sram_en    = en;
      sram_wen   = wen;
      sram_addr  = addr;
      sram_wdata = wdata;
      @(posedge clk);
      modelEdge(en, wen, addr, wdata);
      #1;
      if (do_check) checkAll(tag);
   endtask

   function automatic logic [31:0] randAddr();
      logic [31:0] a;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FFC0) | 32'h40;
      return a;
   endfunction

   initial begin
      modelReset();
      #2 resetn = 1'b0;
      #1 checkAll("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      // Host writes during zero-fill must be ignored
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 4'hF, 32'(($urandom_range(0, 15)) * 4), $urandom, 1'b1, "init");
         if (i == DEPTH - 2) checkOutput("init_15_edges", {31'h0, init_done}, 32'h0);
      end
      checkOutput("init_16_edges", {31'h0, init_done}, 32'h1);

      applyStimulus(1'b1, 4'h0, 32'h3C, 32'h0, 1'b1, "read_3c");
      checkOutput("read_3c_zero", sram_rdata, 32'h0);

      applyStimulus(1'b1, 4'hF, 32'h8, 32'h11223344, 1'b1, "bw_full");
      applyStimulus(1'b1, 4'b0010, 32'h8, 32'hAABBCCDD, 1'b1, "bw_lane1");
      applyStimulus(1'b1, 4'h0, 32'h8, 32'h0, 1'b1, "bw_read");
      checkOutput("byte_write", sram_rdata, 32'h1122CC44);

      applyStimulus(1'b1, 4'hF, 32'h4, 32'h12345678, 1'b1, "rf_setup");
      applyStimulus(1'b1, 4'hF, 32'h4, 32'h0, 1'b1, "rf_rw");
      checkOutput("read_first", sram_rdata, 32'h12345678);
      applyStimulus(1'b1, 4'h0, 32'h4, 32'h0, 1'b1, "rf_after");
      checkOutput("read_first_new", sram_rdata, 32'h0);

      applyStimulus(1'b1, 4'hF, 32'h0, 32'hCAFE0000, 1'b1, "st_setup");
      applyStimulus(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, "st_r0");
      checkOutput("stream_0", sram_rdata, 32'hCAFE0000);
      applyStimulus(1'b1, 4'h0, 32'h4, 32'h0, 1'b1, "st_r4");
      checkOutput("stream_4", sram_rdata, 32'h0);
      applyStimulus(1'b1, 4'h0, 32'h8, 32'h0, 1'b1, "st_r8");
      checkOutput("stream_8", sram_rdata, 32'h1122CC44);
      applyStimulus(1'b0, 4'hF, 32'h0, 32'hFFFFFFFF, 1'b1, "st_hold1");
      applyStimulus(1'b0, 4'h0, 32'h4, 32'h0, 1'b1, "st_hold2");
      checkOutput("stream_hold", sram_rdata, 32'h1122CC44);

      applyStimulus(1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 1'b1, "oor_wr");
      checkOutput("oor_rdata", sram_rdata, 32'h0);
      checkOutput("oor_cnt1", {16'h0, oor_cnt}, 32'h1);
      checkOutput("oor_last", last_err_addr, 32'h40);
      applyStimulus(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, "oor_noalias");
      checkOutput("oor_array_kept", sram_rdata, 32'hCAFE0000);

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom), randAddr(), $urandom, 1'b1, "rand");
      end

      // Asynchronous reset mid-cycle must clear outputs without an edge
      @(negedge clk);
      resetn = 1'b0;
      modelReset();
      #1 checkAll("async_rst");
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < 7; i++) applyStimulus(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, "init2");
      #3 resetn = 1'b0;
      modelReset();
      #1 checkAll("rst_mid_init");
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, "reinit");
      checkOutput("reinit_done", {31'h0, init_done}, 32'h1);
      for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 4'h0, 32'(i * 4), 32'h0, 1'b1, "cleared");

      for (int i = 0; i < 65535; i++) begin
         applyStimulus(1'b1, 4'hF, 32'h40 | 32'(i << 6), 32'hFFFFFFFF, 1'b0, "sat_fill");
      end
      checkAll("sat_reach");
      checkOutput("sat_ffff", {16'h0, oor_cnt}, 32'h0000FFFF);
      applyStimulus(1'b1, 4'hF, 32'h00012340, 32'h5, 1'b1, "sat_more");
      checkOutput("sat_hold", {16'h0, oor_cnt}, 32'h0000FFFF);
      checkOutput("sat_last", last_err_addr, 32'h00012340);
      applyStimulus(1'b1, 4'h0, 32'h0, 32'h0, 1'b1, "sat_noalias");
      checkOutput("sat_array_zero", sram_rdata, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sram_resp.md
SRAM_RESP -- requirements
Module: sram_resp

Interface
REQ-001 The module SHALL take parameter ADDR_W, default 10, as the word-address width (DEPTH = 2^ADDR_W words of 32 bits).
REQ-002 The module SHALL take parameter INIT_ZERO, default 1; 1 enables zero-fill of the array after reset.
REQ-003 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 The module SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port sram_en  input  1  access request this cycle.
REQ-006 The module SHALL have port sram_wen  input  4  byte write enables; bit i covers wdata[8i+7:8i].
REQ-007 The module SHALL have port sram_addr  input  32  byte address.
REQ-008 The module SHALL have port sram_wdata  input  32  write data.
REQ-009 The module SHALL have port sram_rdata  output  32  registered read data.
REQ-010 The module SHALL have port init_done  output  1  high once the array is ready.
REQ-011 The module SHALL have port oor_cnt  output  16  count of out-of-range accesses.
REQ-012 The module SHALL have port last_err_addr  output  32  byte address of the most recent out-of-range access.

Function
REQ-013 Word index SHALL be sram_addr[ADDR_W+1:2]; sram_addr[1:0] ignored.
REQ-014 An access SHALL be out-of-range when sram_addr[31:ADDR_W+2] is non-zero.
REQ-015 FSM SHALL have two states: INIT and READY. After reset: INIT if INIT_ZERO=1, else READY.
REQ-016 In INIT: one word written to 0 per cycle, indices 0 to DEPTH-1 ascending via an ADDR_W-bit counter; READY entered on the edge that clears word DEPTH-1, so INIT lasts exactly DEPTH cycles.
REQ-017 init_done SHALL be 0 in INIT and 1 in READY.
REQ-018 In INIT, host accesses SHALL be ignored: no array write, no counter update; sram_rdata loads 0 on each edge with sram_en=1.
REQ-019 Read latency SHALL be one cycle: sram_en=1 at edge N loads sram_rdata with the word at edge N; the value is valid after edge N.
REQ-020 sram_rdata SHALL hold its value on edges with sram_en=0.
REQ-021 Write: sram_en=1 with sram_wen!=0 in READY and in range SHALL update only the enabled byte lanes at the edge; unenabled lanes are unchanged.
REQ-022 A same-cycle read and write to one word SHALL be read-first: sram_rdata returns the pre-write contents.
REQ-023 An out-of-range access in READY SHALL drop any write, load sram_rdata with 0, capture sram_addr into last_err_addr, and increment oor_cnt.
REQ-024 oor_cnt SHALL saturate at 16'hFFFF; last_err_addr still updates when saturated.
REQ-025 Accesses back-to-back every cycle SHALL be supported with no stall or bubble; no ready/ack signal exists.

Reset
REQ-026 While resetn=0 (asynchronous): sram_rdata=0, oor_cnt=0, last_err_addr=0, init counter=0, FSM forced to INIT (INIT_ZERO=1) or READY (INIT_ZERO=0); init_done follows the FSM.
REQ-027 The array SHALL NOT be reset directly. With INIT_ZERO=1 it is re-cleared by INIT. With INIT_ZERO=0 contents are preserved across reset.
REQ-028 Reset asserted mid-INIT SHALL restart the zero-fill from index 0 after release.

Verification
REQ-029 Init: ADDR_W=4, INIT_ZERO=1, release reset -> init_done rises after exactly 16 clk edges. A read of 0x3C then returns 0.
REQ-030 Byte write: write 0x11223344 (wen=F) to 0x8, then wen=4'b0010 with wdata 0xAABBCCDD, then read 0x8 -> rdata 0x1122CC44 one cycle after the read request.
REQ-031 Read-first: data 0x12345678 at 0x4; same cycle en=1, wen=F, wdata 0 -> rdata 0x12345678; next read of 0x4 -> 0.
REQ-032 Out-of-range: ADDR_W=4, write to 0x40 -> array unchanged, rdata 0, oor_cnt=1, last_err_addr=0x40. Preload oor_cnt to FFFF, repeat -> oor_cnt stays FFFF.
REQ-033 Reset mid-op: assert resetn=0 asynchronously between edges during INIT at index 7 -> rdata and counters 0 immediately. After release, init_done rises 16 edges later.
REQ-034 Hold/streaming: reads of 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive correct rdata values; then en=0 -> rdata holds the 0x8 value.
